tube_arbiter: RTL and testbench
===============================

# tube_arbiter

Round-robin arbiter that shares the single 4-digit seven-segment display between three requesters, such as a counter, a status monitor and a debug value source. It grants the display to one requester at a time and enforces a minimum dwell time so each value stays readable. It drives the 16-bit hex word `data_tube` consumed by the display scan driver. A one-cycle `done` pulse tells a requester its slot has ended.

## Interface
Parameters:
- HOLD_CYCLES, default 50_000_000: minimum number of clock cycles a grant is kept; must be ≥ 1.
- IDLE_WORD, default 16'h0000: value driven on `data_tube` out of reset.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- req  input  3  request per requester; level, held high while the requester wants the display.
- req_data0  input  16  display word from requester 0.
- req_data1  input  16  display word from requester 1.
- req_data2  input  16  display word from requester 2.
- grant  output  3  one-hot grant; 3'b000 when no requester is granted.
- done  output  3  one-cycle pulse on the bit of the requester just released.
- busy  output  1  high while any grant is active; always equals |grant.
- data_tube  output  16  word forwarded to the display driver.

## Operation
- State machine with two states:
  - IDLE: no grant active.
  - HOLD: one requester granted.
- Round-robin pointer `ptr` (0..2) marks the highest-priority requester. Search order is ptr, ptr+1, ptr+2, all mod 3.
- IDLE with req ≠ 0, on a clock edge:
  - Select the first set requester `g` in search order.
  - grant <= onehot(g); data_tube <= req_data[g]; cnt <= 0; state <= HOLD.
- IDLE with req = 0: all outputs hold; data_tube keeps its last value and is never blanked.
- HOLD, on every edge:
  - `cnt` increments and saturates at HOLD_CYCLES-1. Width is clog2(HOLD_CYCLES), minimum 1.
  - If req[g] is high, data_tube <= req_data[g], so live updates reach the display.
  - If req[g] is low, data_tube freezes at its last value.
- Release condition in HOLD: cnt == HOLD_CYCLES-1 AND (req[g] low OR any other req bit high).
- On the release edge:
  - grant <= 0; done[g] <= 1; ptr <= (g+1) mod 3; state <= IDLE.
- Dropping req[g] before the minimum dwell expires does not shorten the grant.
- A sole requester that keeps req high is never released.
- Requests arriving during HOLD wait; no preemption.
- done is high for exactly one cycle and never overlaps grant for the same requester.

## Timing
- Reset values: state IDLE, ptr 0, cnt 0, grant 3'b000, done 3'b000, busy 0, data_tube IDLE_WORD.
- Request to grant: req sampled high at edge n gives grant and data_tube = req_data[g] sampled at edge n, visible after edge n.
- Data latency while granted: 1 cycle.
- Minimum grant length: HOLD_CYCLES cycles.
- Release: grant drops on the same edge that raises done. The next grant comes no earlier than the following edge, so there is a mandatory 1-cycle grant=0 gap between grants.
- Reset asserted mid-HOLD: the next edge forces all reset values. No done pulse is generated.
- A req bit changing in the same cycle as the release edge is evaluated with the sampled value.

## Test plan
All scenarios use HOLD_CYCLES=4 except scenario 6. Cycle numbers are relative to the first request edge.
1. Sole holder with live update:
   - Stimulus: req=3'b001, req_data0=16'h1234 held from edge 0; data changes to 16'h5678 at cycle 10.
   - Required: grant=3'b001 from edge 0 onward and never released; data_tube=16'h1234, then 16'h5678 one cycle after the change; done stays 0.
2. Minimum dwell on a short request:
   - Stimulus: req0 high for one cycle only, req_data0=16'hABCD.
   - Required: grant=3'b001 for exactly 4 cycles; done[0] pulses on the 5th edge; data_tube stays 16'hABCD afterwards; busy=0 after release.
3. Round-robin with all requesters:
   - Stimulus: req=3'b111 held continuously after reset.
   - Required: grant sequence 001, 010, 100, 001; each grant lasts 4 cycles, separated by a 1-cycle grant=000 gap; done pulses on bits 0, 1, 2 in turn; data_tube follows each req_data.
4. Pointer fairness:
   - Stimulus: after requester 1 is released (ptr=2), raise req=3'b011.
   - Required: requester 0 is granted first (search order 2, 0, 1).
5. Reset mid-operation:
   - Stimulus: assert rst while grant=3'b010 at cnt=2.
   - Required: next edge gives grant 000, done 000, data_tube 16'h0000, ptr 0; no done pulse.
6. HOLD_CYCLES=1:
   - Stimulus: req=3'b101 held.
   - Required: grants alternate 001, 100 with 1-cycle grants and 1-cycle gaps.

Source files
------------

// File: rtl/tube_arbiter.sv
// ---------------------------------------------------------------------------
// tube_arbiter
//
// Round-robin arbiter sharing one 4-digit seven-segment display between three
// requesters. A granted requester keeps the display for at least HOLD_CYCLES
// clock cycles so its value stays readable. While it is granted, its live data
// is forwarded to the display driver. It is released only once the dwell has
// expired and either it has dropped its request or another requester is
// waiting. A sole requester that keeps asking therefore keeps the display.
//
// Parameters:
//   HOLD_CYCLES - minimum number of cycles a grant is kept (>= 1)
//   IDLE_WORD   - value on data_tube out of reset
//
// Ports:
//   clk       - clock
//   rst       - synchronous, active-high reset
//   req       - per-requester request level
//   req_data0 - display word from requester 0
//   req_data1 - display word from requester 1
//   req_data2 - display word from requester 2
//   grant     - one-hot grant, 3'b000 when nobody is granted
//   done      - one-cycle pulse on the bit of the requester just released
//   busy      - high while any grant is active (equals |grant)
//   data_tube - 16-bit hex word forwarded to the display scan driver
// ---------------------------------------------------------------------------
module tube_arbiter #(
   parameter int unsigned HOLD_CYCLES = 50_000_000,
   parameter logic [15:0] IDLE_WORD   = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req,
   input  logic [15:0] req_data0,
   input  logic [15:0] req_data1,
   input  logic [15:0] req_data2,
   output logic [2:0]  grant,
   output logic [2:0]  done,
   output logic        busy,
   output logic [15:0] data_tube
);

   // The dwell counter needs at least one bit even when HOLD_CYCLES is 1.
   localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [1:0]        gidx_q, gidx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        grant_q, grant_d;
   logic [2:0]        done_q, done_d;
   logic [15:0]       data_q, data_d;

   logic [1:0]        pick_idx;
   logic [15:0]       pick_data;
   logic [15:0]       own_data;
   logic              own_req;
   logic              others_req;
   logic              release_now;

   // Index 0..2 to one-hot; index 3 never occurs.
   function automatic logic [2:0] onehot(input logic [1:0] i);
      logic [2:0] r;
      case (i)
         2'd0:    r = 3'b001;
         2'd1:    r = 3'b010;
         2'd2:    r = 3'b100;
         default: r = 3'b000;
      endcase
      return r;
   endfunction

   // Modulo-3 increment of a requester index.
   function automatic logic [1:0] wrap_inc(input logic [1:0] i);
      return (i >= 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   // First requester with a request, searching p, p+1, p+2 (mod 3).
   // Only meaningful when at least one request bit is set.
   function automatic logic [1:0] first_req(input logic [2:0] r, input logic [1:0] p);
      logic [1:0] cand;
      logic [1:0] res;
      logic       found;
      cand  = p;
      res   = p;
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (!found && ((r & onehot(cand)) != 3'b000)) begin
            res   = cand;
            found = 1'b1;
         end
         cand = wrap_inc(cand);
      end
      return res;
   endfunction

   // Winner of a fresh arbitration and the word it brings along.
   always_comb begin
      pick_idx = first_req(req, ptr_q);
      case (pick_idx)
         2'd0:    pick_data = req_data0;
         2'd1:    pick_data = req_data1;
         default: pick_data = req_data2;
      endcase
   end

   // Live view of the current holder: its data, whether it still asks, and
   // whether anybody else is waiting for the display.
   always_comb begin
      case (gidx_q)
         2'd0:    own_data = req_data0;
         2'd1:    own_data = req_data1;
         default: own_data = req_data2;
      endcase
      own_req     = (req & onehot(gidx_q)) != 3'b000;
      others_req  = (req & ~onehot(gidx_q)) != 3'b000;
      release_now = (cnt_q == CNT_MAX) && (!own_req || others_req);
   end

   // Next-state and next-output logic. done defaults to zero so it can only
   // ever be a single-cycle pulse; grant and data_tube otherwise hold.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      done_d  = 3'b000;
      data_d  = data_q;

      case (state_q)
         IDLE: begin
            if (req != 3'b000) begin
               gidx_d  = pick_idx;
               grant_d = onehot(pick_idx);
               data_d  = pick_data;
               cnt_d   = '0;
               state_d = HOLD;
            end
         end

         HOLD: begin
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            // A holder that has dropped its request leaves its last word frozen.
            if (own_req) begin
               data_d = own_data;
            end
            // The next grant can only be issued from IDLE, which forces the
            // one-cycle grant=0 gap between consecutive holders.
            if (release_now) begin
               grant_d = 3'b000;
               done_d  = onehot(gidx_q);
               ptr_d   = wrap_inc(gidx_q);
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            grant_d = 3'b000;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         gidx_q  <= 2'd0;
         cnt_q   <= '0;
         grant_q <= 3'b000;
         done_q  <= 3'b000;
         data_q  <= IDLE_WORD;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         data_q  <= data_d;
      end
   end

   assign grant     = grant_q;
   assign done      = done_q;
   assign busy      = |grant_q;
   assign data_tube = data_q;

endmodule

// File: tb/tb_tube_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tube_arbiter
//
// Drives two tube_arbiter instances (HOLD_CYCLES = 4 and HOLD_CYCLES = 1) from
// shared stimulus. A behavioural model per instance tracks who owns the
// display, how long it has owned it and where the round-robin search starts;
// every cycle the outputs of both instances are compared against it. Directed
// scenarios add literal expectations on top of the model.
// ---------------------------------------------------------------------------
module tb_tube_arbiter;

   localparam int HOLD_A = 4;
   localparam int HOLD_B = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [15:0] req_data0, req_data1, req_data2;

   logic [2:0]  grant_a, done_a, grant_b, done_b;
   logic        busy_a, busy_b;
   logic [15:0] tube_a, tube_b;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   // Model state: owner index (-1 = nobody), cycles owned so far, search start.
   int          m_owner [2];
   int          m_age   [2];
   int          m_ptr   [2];
   logic [15:0] m_data  [2];
   logic [2:0]  m_done  [2];

   tube_arbiter #(.HOLD_CYCLES(HOLD_A), .IDLE_WORD(16'h0000)) dut_a (
      .clk(clk), .rst(rst), .req(req),
      .req_data0(req_data0), .req_data1(req_data1), .req_data2(req_data2),
      .grant(grant_a), .done(done_a), .busy(busy_a), .data_tube(tube_a)
   );

   tube_arbiter #(.HOLD_CYCLES(HOLD_B), .IDLE_WORD(16'h0000)) dut_b (
      .clk(clk), .rst(rst), .req(req),
      .req_data0(req_data0), .req_data1(req_data1), .req_data2(req_data2),
      .grant(grant_b), .done(done_b), .busy(busy_b), .data_tube(tube_b)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One clock edge of the arbitration rules for model instance i.
   task automatic model_step(input int i, input int h);
      logic [15:0] rd [3];
      rd[0] = req_data0;
      rd[1] = req_data1;
      rd[2] = req_data2;
      if (rst) begin
         m_owner[i] = -1;
         m_age[i]   = 0;
         m_ptr[i]   = 0;
         m_data[i]  = 16'h0000;
         m_done[i]  = 3'b000;
      end else begin
         m_done[i] = 3'b000;
         if (m_owner[i] < 0) begin
            for (int k = 0; k < 3; k++) begin
               int c;
               c = (m_ptr[i] + k) % 3;
               if (m_owner[i] < 0 && req[c]) begin
                  m_owner[i] = c;
                  m_age[i]   = 1;
                  m_data[i]  = rd[c];
               end
            end
         end else begin
            int o;
            bit others;
            o = m_owner[i];
            if (req[o]) m_data[i] = rd[o];
            others = 1'b0;
            for (int k = 0; k < 3; k++) begin
               if (k != o && req[k]) others = 1'b1;
            end
            if (m_age[i] >= h && (!req[o] || others)) begin
               m_done[i][o] = 1'b1;
               m_ptr[i]     = (o + 1) % 3;
               m_owner[i]   = -1;
            end else begin
               m_age[i]++;
            end
         end
      end
   endtask

   function automatic logic [2:0] exp_grant(input int i);
      return (m_owner[i] < 0) ? 3'b000 : (3'b001 << m_owner[i]);
   endfunction

   // Model advances on the same edge as the DUTs; inputs only change on negedges.
   always @(posedge clk) begin
      model_step(0, HOLD_A);
      model_step(1, HOLD_B);
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (check_en) begin
         check_output("a.grant", {13'b0, grant_a}, {13'b0, exp_grant(0)});
         check_output("a.done",  {13'b0, done_a},  {13'b0, m_done[0]});
         check_output("a.busy",  {15'b0, busy_a},  {15'b0, (m_owner[0] >= 0)});
         check_output("a.tube",  tube_a,           m_data[0]);
         check_output("b.grant", {13'b0, grant_b}, {13'b0, exp_grant(1)});
         check_output("b.done",  {13'b0, done_b},  {13'b0, m_done[1]});
         check_output("b.busy",  {15'b0, busy_b},  {15'b0, (m_owner[1] >= 0)});
         check_output("b.tube",  tube_b,           m_data[1]);
      end
   end

   task automatic apply_stimulus(input logic [2:0] r, input logic [15:0] a,
                                 input logic [15:0] b, input logic [15:0] c);
      req       = r;
      req_data0 = a;
      req_data1 = b;
      req_data2 = c;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [2:0] g_exp;
      for (int i = 0; i < 2; i++) begin
         m_owner[i] = -1; m_age[i] = 0; m_ptr[i] = 0;
         m_data[i] = 16'h0000; m_done[i] = 3'b000;
      end
      rst = 1'b1;
      apply_stimulus(3'b000, 16'h0000, 16'h0000, 16'h0000);
      step();
      step();

      // Reset state
      check_output("rst.grant", {13'b0, grant_a}, 16'h0000);
      check_output("rst.done",  {13'b0, done_a},  16'h0000);
      check_output("rst.busy",  {15'b0, busy_a},  16'h0000);
      check_output("rst.tube",  tube_a,           16'h0000);
      rst      = 1'b0;
      check_en = 1'b1;

      // Sole holder with live update
      apply_stimulus(3'b001, 16'h1234, 16'h0000, 16'h0000);
      step();
      check_output("s1.grant", {13'b0, grant_a}, 16'h0001);
      check_output("s1.tube",  tube_a,           16'h1234);
      for (int t = 1; t < 10; t++) begin
         step();
         check_output("s1.hold", {13'b0, grant_a}, 16'h0001);
         check_output("s1.done", {13'b0, done_a},  16'h0000);
      end
      req_data0 = 16'h5678;
      step();
      check_output("s1.live", tube_a, 16'h5678);
      req = 3'b000;
      step();
      check_output("s1.rel_done",  {13'b0, done_a},  16'h0001);
      check_output("s1.rel_grant", {13'b0, grant_a}, 16'h0000);
      step();

      // Minimum dwell on a one-cycle request
      apply_stimulus(3'b001, 16'hABCD, 16'h0000, 16'h0000);
      step();
      req = 3'b000;
      check_output("s2.grant0", {13'b0, grant_a}, 16'h0001);
      for (int t = 1; t < 4; t++) begin
         step();
         check_output("s2.grant", {13'b0, grant_a}, 16'h0001);
      end
      step();
      check_output("s2.done",  {13'b0, done_a},  16'h0001);
      check_output("s2.grant_off", {13'b0, grant_a}, 16'h0000);
      check_output("s2.busy",  {15'b0, busy_a},  16'h0000);
      check_output("s2.tube",  tube_a,           16'hABCD);
      step();

      // Round robin with all three requesting from reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      apply_stimulus(3'b111, 16'h1111, 16'h2222, 16'h3333);
      for (int t = 0; t < 16; t++) begin
         step();
         g_exp = 3'b001 << ((t / 5) % 3);
         if (t % 5 == 4) begin
            check_output("s3.gap",  {13'b0, grant_a}, 16'h0000);
            check_output("s3.done", {13'b0, done_a},  {13'b0, g_exp});
         end else begin
            check_output("s3.grant", {13'b0, grant_a}, {13'b0, g_exp});
            check_output("s3.tube",  tube_a, 16'h1111 * 16'(((t / 5) % 3) + 1));
         end
      end

      // Pointer fairness: after requester 1 is released, 0 goes before 1
      rst = 1'b1;
      step();
      rst = 1'b0;
      apply_stimulus(3'b010, 16'h0A0A, 16'h0B0B, 16'h0C0C);
      step();
      check_output("s4.grant1", {13'b0, grant_a}, 16'h0002);
      req = 3'b000;
      for (int t = 0; t < 3; t++) step();
      step();
      check_output("s4.done1", {13'b0, done_a}, 16'h0002);
      req = 3'b011;
      step();
      check_output("s4.fair", {13'b0, grant_a}, 16'h0001);

      // Reset while requester 1 holds at cnt=2
      for (int t = 0; t < 3; t++) step();
      step();
      check_output("s5.done0", {13'b0, done_a}, 16'h0001);
      step();
      check_output("s5.grant1", {13'b0, grant_a}, 16'h0002);
      step();
      step();
      rst = 1'b1;
      step();
      check_output("s5.grant", {13'b0, grant_a}, 16'h0000);
      check_output("s5.done",  {13'b0, done_a},  16'h0000);
      check_output("s5.tube",  tube_a,           16'h0000);
      rst = 1'b0;
      apply_stimulus(3'b011, 16'hBEEF, 16'h0B0B, 16'h0C0C);
      step();
      check_output("s5.ptr0", {13'b0, grant_a}, 16'h0001);
      check_output("s5.nodone", {13'b0, done_a}, 16'h0000);

      // HOLD_CYCLES=1 alternation
      rst = 1'b1;
      step();
      rst = 1'b0;
      apply_stimulus(3'b101, 16'h0101, 16'h0202, 16'h0303);
      for (int t = 0; t < 8; t++) begin
         step();
         if (t % 2 == 1) g_exp = 3'b000;
         else            g_exp = ((t / 2) % 2 == 1) ? 3'b100 : 3'b001;
         check_output("s6.grant", {13'b0, grant_b}, {13'b0, g_exp});
      end

      // Randomized traffic, occasional resets
      for (int t = 0; t < 1500; t++) begin
         rst = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 0) req_data0 = 16'($urandom);
         if ($urandom_range(0, 1) == 0) req_data1 = 16'($urandom);
         if ($urandom_range(0, 1) == 0) req_data2 = 16'($urandom);
         step();
      end

      check_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
